// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the fifo write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int CNT_W  = 5;
   localparam int STAT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of req at or after start, modulo N.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic          valid,
   output logic [IW-1:0] idx
);

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         int pos;
         pos = (int'(start) + k) % N;
         if (!valid && req[pos]) begin
            valid = 1'b1;
            idx   = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-limited round-robin arbiter sharing one fifo write port among NUM_REQ requesters.
// Define FIFO_ARB_STATS_EN to add per-requester saturating write counters on wr_count.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_WIDTH = 32,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          wr_en,
   output logic [FIFO_WIDTH-1:0]         data_in,
   input  logic                          full
`ifdef FIFO_ARB_STATS_EN
   ,output logic [NUM_REQ*STAT_W-1:0]    wr_count
`endif
);

   localparam int IW = $clog2(NUM_REQ);

   arb_state_t       state;
   logic [IW-1:0]    owner;
   logic [CNT_W-1:0] burst_cnt;
   logic [IW-1:0]    rr_ptr;

   arb_state_t       state_n;
   logic [IW-1:0]    owner_n;
   logic [CNT_W-1:0] burst_cnt_n;
   logic [IW-1:0]    rr_ptr_n;

   logic [NUM_REQ-1:0]    gnt_c;
   logic [FIFO_WIDTH-1:0] data_c;
   logic [IW-1:0]         owner_nxt;
   logic                  rel;
   logic [NUM_REQ-1:0]    pick_req;
   logic [IW-1:0]         pick_start;
   logic                  pick_vld;
   logic [IW-1:0]         pick_idx;

   assign owner_nxt = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);

   // On release the outgoing owner is masked so other requesters get a turn first.
   always_comb begin
      pick_req   = req;
      pick_start = rr_ptr;
      rel        = 1'b0;
      if (state == BURST) begin
         rel        = !req[owner] || (burst_cnt >= CNT_W'(MAX_BURST));
         pick_req   = req & ~(NUM_REQ'(1) << owner);
         pick_start = owner_nxt;
      end
   end

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req   (pick_req),
      .start (pick_start),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   always_comb begin
      gnt_c       = '0;
      state_n     = state;
      owner_n     = owner;
      burst_cnt_n = burst_cnt;
      rr_ptr_n    = rr_ptr;
      case (state)
         IDLE: begin
            if (pick_vld && !full) begin
               gnt_c[pick_idx] = 1'b1;
               owner_n         = pick_idx;
               burst_cnt_n     = CNT_W'(1);
               state_n         = BURST;
            end
         end
         BURST: begin
            if (rel) begin
               rr_ptr_n = owner_nxt;
               if (pick_vld && !full) begin
                  gnt_c[pick_idx] = 1'b1;
                  owner_n         = pick_idx;
                  burst_cnt_n     = CNT_W'(1);
               end else begin
                  state_n = IDLE;
               end
            end else if (!full) begin
               gnt_c[owner] = 1'b1;
               burst_cnt_n  = burst_cnt + CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
      if (rst) gnt_c = '0;
   end

   always_comb begin
      data_c = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (gnt_c[i]) data_c = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
   end

   assign gnt     = gnt_c;
   assign wr_en   = |gnt_c;
   assign data_in = data_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= '0;
         burst_cnt <= '0;
         rr_ptr    <= '0;
      end else begin
         state     <= state_n;
         owner     <= owner_n;
         burst_cnt <= burst_cnt_n;
         rr_ptr    <= rr_ptr_n;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [STAT_W-1:0] wr_cnt_q [NUM_REQ];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rst)
            wr_cnt_q[i] <= '0;
         else if (gnt_c[i] && (wr_cnt_q[i] != '1))
            wr_cnt_q[i] <= wr_cnt_q[i] + STAT_W'(1);
      end
   end

   always_comb begin
      wr_count = '0;
      for (int i = 0; i < NUM_REQ; i++)
         wr_count[i*STAT_W +: STAT_W] = wr_cnt_q[i];
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: burst limit, fairness, full stall, early drop, reset.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   logic        clk;
   logic        rst;
   logic [3:0]  req,  req2;
   logic [127:0] req_data, req_data2;
   logic [3:0]  gnt,  gnt2;
   logic        wr_en, wr_en2;
   logic [31:0] data_in, data_in2;
   logic        full, full2;
`ifdef FIFO_ARB_STATS_EN
   logic [63:0] wr_count, wr_count2;
`endif

   int n_chk = 0;
   int n_bad = 0;

   fifo_wr_arbiter #(.NUM_REQ(4), .FIFO_WIDTH(32), .MAX_BURST(4)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .gnt      (gnt),
      .wr_en    (wr_en),
      .data_in  (data_in),
      .full     (full)
`ifdef FIFO_ARB_STATS_EN
      ,.wr_count (wr_count)
`endif
   );

   fifo_wr_arbiter #(.NUM_REQ(4), .FIFO_WIDTH(32), .MAX_BURST(2)) u_dut2 (
      .clk      (clk),
      .rst      (rst),
      .req      (req2),
      .req_data (req_data2),
      .gnt      (gnt2),
      .wr_en    (wr_en2),
      .data_in  (data_in2),
      .full     (full2)
`ifdef FIFO_ARB_STATS_EN
      ,.wr_count (wr_count2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   k;
      logic g;
      logic expg;
      int   e;

      rst = 1'b1; full = 1'b0; full2 = 1'b0;
      req = '0; req2 = '0;
      for (int i = 0; i < 4; i++) begin
         req_data[i*32 +: 32]  = 32'hD0 + i;
         req_data2[i*32 +: 32] = 32'hA0 + i;
      end
      tick(); tick();

      // outputs stay quiet while reset is held, even with requests pending
      req = 4'b1111; req2 = 4'b1111;
      @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_data", data_in, 0);
      chk("rst_gnt2", gnt2, 0);
      tick();
      chk("rst_state", u_dut.state, IDLE);
      chk("rst_rr_ptr", u_dut.rr_ptr, 0);
      req = '0; rst = 1'b0;

      // fairness with MAX_BURST=2: 0,0,1,1,2,2,3,3,0,0
      for (int c = 0; c < 10; c++) begin
         e = (c / 2) % 4;
         @(negedge clk);
         chk($sformatf("fair_gnt_%0d", c), gnt2, 4'b0001 << e);
         chk($sformatf("fair_data_%0d", c), data_in2, 32'hA0 + e);
         tick();
      end
      req2 = '0;
      tick();

      // single requester, MAX_BURST=4: four writes, one idle cycle, two more
      k = 0;
      for (int c = 0; c < 8; c++) begin
         req = (k < 6) ? 4'b0001 : 4'b0000;
         req_data[31:0] = 32'd10 + k;
         expg = (c < 4) || (c == 5) || (c == 6);
         @(negedge clk);
         g = gnt[0];
         chk($sformatf("single_gnt_%0d", c), gnt, expg ? 4'b0001 : 4'b0000);
         chk($sformatf("single_wr_en_%0d", c), wr_en, expg);
         chk($sformatf("single_data_%0d", c), data_in, expg ? 32'd10 + k : 32'd0);
         tick();
         if (g) k++;
      end
      chk("single_writes", k, 6);

      // owner 2 stalled by full after one write, then resumes
      k = 0;
      for (int c = 0; c < 8; c++) begin
         req  = (k < 4) ? 4'b0100 : 4'b0000;
         req_data[64 +: 32] = 32'h200 + k;
         full = (c >= 1) && (c <= 3);
         expg = (c == 0) || ((c >= 4) && (c <= 6));
         @(negedge clk);
         g = gnt[2];
         chk($sformatf("stall_gnt_%0d", c), gnt, expg ? 4'b0100 : 4'b0000);
         chk($sformatf("stall_data_%0d", c), data_in, expg ? 32'h200 + k : 32'd0);
         tick();
         if (g) k++;
         if (c == 3) chk("stall_hold_cnt", u_dut.burst_cnt, 1);
         if (c == 4) chk("stall_resume_cnt", u_dut.burst_cnt, 2);
      end
      full = 1'b0;
      chk("stall_writes", k, 4);

      // owner 1 drops after one write while 3 waits
      req_data[32 +: 32] = 32'h111;
      req_data[96 +: 32] = 32'h333;
      req = 4'b0010;
      @(negedge clk);
      chk("drop_first_gnt", gnt, 4'b0010);
      chk("drop_first_data", data_in, 32'h111);
      tick();
      req = 4'b1000;
      @(negedge clk);
      chk("drop_regrant", gnt, 4'b1000);
      chk("drop_regrant_data", data_in, 32'h333);
      tick();
      chk("drop_rr_ptr", u_dut.rr_ptr, 2);
      chk("drop_owner", u_dut.owner, 3);
      @(negedge clk);
      chk("owner3_burst", gnt, 4'b1000);
      tick();

      // reset in the middle of owner 3's burst
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_gnt", gnt, 0);
      chk("midrst_wr_en", wr_en, 0);
      chk("midrst_data", data_in, 0);
      tick();
      chk("midrst_state", u_dut.state, IDLE);
      chk("midrst_owner", u_dut.owner, 0);
      chk("midrst_cnt", u_dut.burst_cnt, 0);
      chk("midrst_rr_ptr", u_dut.rr_ptr, 0);
      rst = 1'b0;
      req = 4'b1010;
      @(negedge clk);
      chk("postrst_gnt", gnt, 4'b0010);
      chk("postrst_data", data_in, 32'h111);
      tick();
      req = '0;
      tick();

`ifdef FIFO_ARB_STATS_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      k = 0;
      for (int c = 0; c < 40 && k < 20; c++) begin
         req = 4'b0001;
         @(negedge clk);
         g = gnt[0];
         tick();
         if (g) k++;
      end
      req = '0;
      tick();
      chk("stats_writes", k, 20);
      chk("stats_cnt0", wr_count[15:0], 20);
      chk("stats_cnt1", wr_count[31:16], 0);
      chk("stats_cnt2", wr_count[47:32], 0);
      chk("stats_cnt3", wr_count[63:48], 0);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the fifo write port; legal range 2..8.
REQ-002 Parameter FIFO_WIDTH, default 32: data width; it SHALL match the attached fifo.
REQ-003 Parameter MAX_BURST, default 4: maximum number of consecutive writes by one owner; legal range 1..16.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port req, input, NUM_REQ bits: per-requester write request; the requester SHALL hold req and its data until granted.
REQ-007 Port req_data, input, NUM_REQ*FIFO_WIDTH bits: write data, packed flat; requester i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-008 Port gnt, output, NUM_REQ bits: one-hot-or-zero grant; the write is accepted at the rising edge on which gnt[i] is high.
REQ-009 Port wr_en, output, 1 bit: drives the fifo wr_en input.
REQ-010 Port data_in, output, FIFO_WIDTH bits: drives the fifo data_in input.
REQ-011 Port full, input, 1 bit: the fifo full flag.

Function
REQ-012 gnt, wr_en and data_in SHALL be combinational from the registered state and from req/full, giving zero-cycle grant latency.
REQ-013 wr_en SHALL equal the OR of gnt.
REQ-014 data_in SHALL equal req_data of the granted requester, and SHALL be all zeros when no requester is granted.
REQ-015 No gnt bit SHALL assert in any cycle in which full=1, so no write is ever issued to a full fifo.
REQ-016 The FSM SHALL have two states, IDLE and BURST, with registers owner (clog2 NUM_REQ bits), burst_cnt (5 bits) and rr_ptr (clog2 NUM_REQ bits).
REQ-017 IDLE, any req high and full=0: the block SHALL grant the first requester at or after rr_ptr in modulo-NUM_REQ order, set owner to it, set burst_cnt=1 and go to BURST.
REQ-018 BURST, req[owner]=1, full=0 and burst_cnt<MAX_BURST: the block SHALL grant owner and increment burst_cnt.
REQ-019 BURST, req[owner]=0 or burst_cnt==MAX_BURST (release): the block SHALL set rr_ptr=owner+1 (wrapping) and re-arbitrate in the same cycle as IDLE, starting from owner+1.
REQ-020 On release, if the re-arbitration finds no eligible request, or full=1, the block SHALL go to IDLE.
REQ-021 BURST with full=1 and req[owner]=1: the block SHALL issue no grant and hold state, owner and burst_cnt (the lock is kept).
REQ-022 BURST with full=1 and req[owner]=0: the block SHALL go to IDLE with rr_ptr=owner+1.
REQ-023 With MAX_BURST=1, every grant SHALL be followed by release, giving pure round-robin.

Reset
REQ-024 With rst=1 at a rising edge, the block SHALL set state=IDLE, owner=0, burst_cnt=0 and rr_ptr=0, including when reset arrives mid-burst.
REQ-025 While rst=1, gnt SHALL be 0, wr_en SHALL be 0 and data_in SHALL be 0.

Configuration
REQ-026 With macro FIFO_ARB_STATS_EN defined, the block SHALL add output wr_count (NUM_REQ*16 bits): per-requester saturating write counters, incremented on each granted write, held at 16'hFFFF when saturated, and cleared by rst.
REQ-027 Without FIFO_ARB_STATS_EN, the wr_count port and its counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 The state enum (IDLE, BURST) and the counter width constant SHALL live in the shared package fifo_arb_pkg.
REQ-029 The rotating priority pick SHALL be one sub-module, rr_pick (combinational: req vector plus start index in, valid and index out), reused for both the IDLE pick and the release-cycle re-arbitration.

Verification
REQ-030 Scenario single requester: req=4'b0001 held for 6 cycles, MAX_BURST=4, data 10..15 -> grants on cycles 1-4, 1 released cycle with gnt=0 to 4'b0001 re-granted next cycle (it wins again as the sole requester), and the fifo receives 10,11,12,13,14,15 in order.
REQ-031 Scenario fairness: req=4'b1111 held, MAX_BURST=2 -> grant order is 0,0,1,1,2,2,3,3,0,...
REQ-032 Scenario full stall: owner 2 mid-burst with burst_cnt=1, full pulsed high for 3 cycles -> gnt=0 for 3 cycles, then owner 2 resumes with burst_cnt=2 and no write is lost or duplicated.
REQ-033 Scenario early drop: owner 1 drops req after 1 write while req[3]=1 -> in the same cycle gnt=4'b1000 and rr_ptr=2.
REQ-034 Scenario reset mid-burst: rst asserted during owner=3 burst -> next cycle gnt=0 and state IDLE; after release, req=4'b1010 is granted to requester 1 first.
REQ-035 Scenario stats (with FIFO_ARB_STATS_EN): 20 granted writes from requester 0 -> wr_count[0]=20 and all other counters 0.
